icache_assoc: RTL

- Parametrised N-way set-associative instruction cache with a single outstanding miss.
- Sits between the fetch stage and the L2 line interface, and is the successor of the direct-mapped instruction cache.
- Adds configurable associativity and a per-set round-robin victim pointer.
- Adds valid/ready handshakes on both the CPU side and the L2 side, plus flush-safe miss handling.

---
 rtl/icache_assoc_if.sv | 34 +++
 rtl/icache_assoc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/icache_assoc_if.sv
// Bus bundle for the associative instruction cache: CPU fetch side, L2 refill side and flush.
// The cache connects through the slave modport; the fetch stage / L2 model uses master.
interface icache_assoc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 8
);
    localparam int OFF_W = $clog2(DATA_WIDTH * BLOCK_SIZE / 8);

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
    // the source holds VALID and its payload stable until that edge. DATA_FROM_L2_VALID and
    // CPU_DATA_VALID are single-cycle pulses with no back-pressure.
    logic                             FLUSH;
    logic [ADDR_WIDTH-1:0]            CPU_ADDR;
    logic                             CPU_ADDR_VALID;
    logic                             CPU_ADDR_READY;
    logic [DATA_WIDTH-1:0]            CPU_DATA;
    logic                             CPU_DATA_VALID;
    logic [ADDR_WIDTH-OFF_W-1:0]      ADDR_TO_L2;
    logic                             ADDR_TO_L2_VALID;
    logic                             ADDR_TO_L2_READY;
    logic [DATA_WIDTH*BLOCK_SIZE-1:0] DATA_FROM_L2;
    logic                             DATA_FROM_L2_VALID;

    modport slave (
        input  FLUSH, CPU_ADDR, CPU_ADDR_VALID, ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID,
        output CPU_ADDR_READY, CPU_DATA, CPU_DATA_VALID, ADDR_TO_L2, ADDR_TO_L2_VALID
    );

    modport master (
        output FLUSH, CPU_ADDR, CPU_ADDR_VALID, ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID,
        input  CPU_ADDR_READY, CPU_DATA, CPU_DATA_VALID, ADDR_TO_L2, ADDR_TO_L2_VALID
    );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache, one outstanding miss, per-set round-robin
// replacement once every way of a set is valid.
module icache_assoc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int SETS       = 128,
    parameter int WAYS       = 2
) (
    input  logic              CLK,
    input  logic              RST,
    icache_assoc_if.slave     bus,
    output logic [2:0]        dbg_state
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(DATA_WIDTH * BLOCK_SIZE / 8);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int WB_W   = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W = $clog2(BLOCK_SIZE);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = DATA_WIDTH * BLOCK_SIZE;
    localparam int RA_W   = ADDR_WIDTH - WB_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_REFILL
    } state_t;

    state_t            state_q, state_d;
    logic [RA_W-1:0]   req_addr_q, req_addr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              by_rr_q, by_rr_d;
    logic              discard_q, discard_d;

    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [SETS-1:0]   valid_q [WAYS];
    logic [WAY_W-1:0]  rr_q    [SETS];

    // The request register keeps the word address only; byte-within-word bits never matter.
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;

    assign req_tag  = req_addr_q[RA_W-1 -: TAG_W];
    assign req_idx  = req_addr_q[WORD_W +: IDX_W];
    assign req_word = req_addr_q[WORD_W-1:0];

    logic              hit;
    logic [LINE_W-1:0] hit_line;
    logic [DATA_WIDTH-1:0] hit_word;
    logic              vic_inv;
    logic [WAY_W-1:0]  vic_way;
    logic              fill_we;

    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit      = 1'b1;
                hit_line = data_q[w][req_idx];
            end
        end
        hit_word = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (req_word == WORD_W'(i)) hit_word = hit_line[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scanning downwards leaves the lowest-index invalid way selected; rr only when the set is full.
    always_comb begin
        vic_inv = 1'b0;
        vic_way = rr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                vic_inv = 1'b1;
                vic_way = WAY_W'(w);
            end
        end
    end

    assign fill_we   = (state_q == S_MISS_WAIT) && bus.DATA_FROM_L2_VALID;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        victim_d   = victim_q;
        by_rr_d    = by_rr_q;
        discard_d  = discard_q;

        bus.CPU_ADDR_READY   = 1'b0;
        bus.CPU_DATA_VALID   = 1'b0;
        bus.CPU_DATA         = '0;
        bus.ADDR_TO_L2_VALID = 1'b0;
        bus.ADDR_TO_L2       = '0;

        unique case (state_q)
            S_IDLE: begin
                bus.CPU_ADDR_READY = 1'b1;
                if (bus.CPU_ADDR_VALID) begin
                    req_addr_d = bus.CPU_ADDR[ADDR_WIDTH-1:WB_W];
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    bus.CPU_ADDR_READY = 1'b1;
                    bus.CPU_DATA_VALID = 1'b1;
                    bus.CPU_DATA       = hit_word;
                    if (bus.CPU_ADDR_VALID) begin
                        req_addr_d = bus.CPU_ADDR[ADDR_WIDTH-1:WB_W];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    victim_d = vic_way;
                    by_rr_d  = !vic_inv;
                    state_d  = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                bus.ADDR_TO_L2_VALID = 1'b1;
                bus.ADDR_TO_L2       = req_addr_q[RA_W-1:WORD_W];
                if (bus.ADDR_TO_L2_READY) state_d = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (bus.DATA_FROM_L2_VALID) state_d = S_REFILL;
            end
            S_REFILL: begin
                state_d = S_LOOKUP;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush while a miss is in flight must not let the stale refill become valid.
        if (state_q == S_REFILL) begin
            discard_d = 1'b0;
        end else if (bus.FLUSH && (state_q == S_MISS_REQ || state_q == S_MISS_WAIT)) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            victim_q   <= '0;
            by_rr_q    <= 1'b0;
            discard_q  <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            victim_q   <= victim_d;
            by_rr_q    <= by_rr_d;
            discard_q  <= discard_d;
            if (bus.FLUSH) begin
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end else if (fill_we && !discard_q) begin
                valid_q[victim_q][req_idx] <= 1'b1;
            end
            if (fill_we && by_rr_q) begin
                rr_q[req_idx] <= (WAYS > 1) ? rr_q[req_idx] + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_q[victim_q][req_idx] <= bus.DATA_FROM_L2;
            tag_q[victim_q][req_idx]  <= req_tag;
        end
    end
endmodule
